// File: rtl/cp0_excp_unit.sv
// CP0 register file and exception/interrupt sequencer for the 5-stage MIPS core.
// Produces the combinational flush-and-redirect request for the pipeline controller.
module cp0_excp_unit #(
   parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        mem_valid,
   input  logic        mem_stall,
   input  logic        excp_req,
   input  logic [4:0]  excp_code,
   input  logic [31:0] excp_pc,
   input  logic        excp_bd,
   input  logic [31:0] excp_badvaddr,
   input  logic        eret,
   input  logic [5:0]  ext_int,
   input  logic        cp0_we,
   input  logic [4:0]  cp0_waddr,
   input  logic [31:0] cp0_wdata,
   input  logic [4:0]  cp0_raddr,
   output logic [31:0] cp0_rdata,
   output logic [32:0] CP0_to_ctrl_bus
);

   localparam int unsigned XLEN = 32;
   localparam int unsigned RW   = 5;

   localparam logic [RW-1:0] REG_BADVADDR = 5'd8;
   localparam logic [RW-1:0] REG_COUNT    = 5'd9;
   localparam logic [RW-1:0] REG_COMPARE  = 5'd11;
   localparam logic [RW-1:0] REG_STATUS   = 5'd12;
   localparam logic [RW-1:0] REG_CAUSE    = 5'd13;
   localparam logic [RW-1:0] REG_EPC      = 5'd14;

   localparam logic [XLEN-1:0] STATUS_WMASK = 32'h0000_FF03;
   localparam logic [XLEN-1:0] CAUSE_WMASK  = 32'h0000_0300;

   logic [XLEN-1:0] badvaddr_q, badvaddr_d;
   logic [XLEN-1:0] count_q,    count_d;
   logic [XLEN-1:0] compare_q,  compare_d;
   logic [XLEN-1:0] epc_q,      epc_d;
   logic [7:0]      im_q,       im_d;
   logic            exl_q,      exl_d;
   logic            ie_q,       ie_d;
   logic            bd_q,       bd_d;
   logic            ti_q,       ti_d;
   logic [5:0]      ip_hw_q,    ip_hw_d;
   logic [1:0]      ip_sw_q,    ip_sw_d;
   logic [4:0]      exccode_q,  exccode_d;
   logic            phase_q,    phase_d;

   logic [7:0]      ip_c;
   logic [XLEN-1:0] status_c;
   logic [XLEN-1:0] cause_c;
   logic            int_pend_c;
   logic            evt_ok_c;
   logic            exc_take_c;
   logic            eret_take_c;
   logic            wr_take_c;
   logic [XLEN-1:0] wr_masked_c;

   // Architectural views of Status and Cause; the timer interrupt shares IP7 with ext_int[5]
   assign ip_c     = {ip_hw_q[5] | ti_q, ip_hw_q[4:0], ip_sw_q};
   assign status_c = {9'd0, 1'b1, 6'd0, im_q, 6'd0, exl_q, ie_q};
   assign cause_c  = {bd_q, ti_q, 14'd0, ip_c, 1'b0, exccode_q, 2'b00};

   assign int_pend_c  = ie_q & ~exl_q & (|(ip_c & im_q));
   assign evt_ok_c    = resetn & mem_valid & ~mem_stall;
   assign exc_take_c  = evt_ok_c & (int_pend_c | excp_req);
   assign eret_take_c = evt_ok_c & ~exc_take_c & eret;
   assign wr_take_c   = evt_ok_c & ~exc_take_c & ~eret_take_c & cp0_we;

   always_comb begin
      CP0_to_ctrl_bus = 33'd0;
      if (exc_take_c) begin
         CP0_to_ctrl_bus = {1'b1, EXC_VECTOR};
      end else if (eret_take_c) begin
         CP0_to_ctrl_bus = {1'b1, epc_q};
      end
   end

   always_comb begin
      wr_masked_c = '0;
      case (cp0_waddr)
         REG_COUNT:   wr_masked_c = cp0_wdata;
         REG_COMPARE: wr_masked_c = cp0_wdata;
         REG_STATUS:  wr_masked_c = cp0_wdata & STATUS_WMASK;
         REG_CAUSE:   wr_masked_c = cp0_wdata & CAUSE_WMASK;
         REG_EPC:     wr_masked_c = cp0_wdata;
         default:     wr_masked_c = '0;
      endcase
   end

   // MFC0 read mux with same-cycle MTC0 bypass
   always_comb begin
      cp0_rdata = '0;
      case (cp0_raddr)
         REG_BADVADDR: cp0_rdata = badvaddr_q;
         REG_COUNT:    cp0_rdata = count_q;
         REG_COMPARE:  cp0_rdata = compare_q;
         REG_STATUS:   cp0_rdata = status_c;
         REG_CAUSE:    cp0_rdata = cause_c;
         REG_EPC:      cp0_rdata = epc_q;
         default:      cp0_rdata = '0;
      endcase
      if (wr_take_c && (cp0_raddr == cp0_waddr)) begin
         cp0_rdata = wr_masked_c;
      end
   end

   always_comb begin
      badvaddr_d = badvaddr_q;
      compare_d  = compare_q;
      epc_d      = epc_q;
      im_d       = im_q;
      exl_d      = exl_q;
      ie_d       = ie_q;
      bd_d       = bd_q;
      ti_d       = ti_q;
      ip_sw_d    = ip_sw_q;
      exccode_d  = exccode_q;
      ip_hw_d    = ext_int;
      phase_d    = ~phase_q;
      count_d    = phase_q ? count_q + 32'd1 : count_q;

      if (wr_take_c && (cp0_waddr == REG_COUNT)) begin
         count_d = cp0_wdata;
         phase_d = 1'b0;
      end
      if ((count_d == compare_q) && (compare_q != '0)) begin
         ti_d = 1'b1;
      end

      if (wr_take_c) begin
         case (cp0_waddr)
            REG_COMPARE: begin
               compare_d = cp0_wdata;
               ti_d      = 1'b0;
            end
            REG_STATUS: begin
               im_d  = cp0_wdata[15:8];
               exl_d = cp0_wdata[1];
               ie_d  = cp0_wdata[0];
            end
            REG_CAUSE: ip_sw_d = cp0_wdata[9:8];
            REG_EPC:   epc_d   = cp0_wdata;
            default: ;
         endcase
      end

      // Nested exceptions keep the original EPC/BD so ERET returns to the outermost fault
      if (exc_take_c) begin
         exccode_d = int_pend_c ? 5'h00 : excp_code;
         exl_d     = 1'b1;
         if (!exl_q) begin
            epc_d = excp_bd ? excp_pc - 32'd4 : excp_pc;
            bd_d  = excp_bd;
         end
         if (!int_pend_c && ((excp_code == 5'h04) || (excp_code == 5'h05))) begin
            badvaddr_d = excp_badvaddr;
         end
      end

      if (eret_take_c) begin
         exl_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         badvaddr_q <= '0;
         count_q    <= '0;
         compare_q  <= '0;
         epc_q      <= '0;
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ti_q       <= 1'b0;
         ip_hw_q    <= '0;
         ip_sw_q    <= '0;
         exccode_q  <= '0;
         phase_q    <= 1'b0;
      end else begin
         badvaddr_q <= badvaddr_d;
         count_q    <= count_d;
         compare_q  <= compare_d;
         epc_q      <= epc_d;
         im_q       <= im_d;
         exl_q      <= exl_d;
         ie_q       <= ie_d;
         bd_q       <= bd_d;
         ti_q       <= ti_d;
         ip_hw_q    <= ip_hw_d;
         ip_sw_q    <= ip_sw_d;
         exccode_q  <= exccode_d;
         phase_q    <= phase_d;
      end
   end

endmodule

// File: tb/tb_cp0_excp_unit.sv
// Directed bench for cp0_excp_unit: stimulus queues expected bus/read values per cycle,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_cp0_excp_unit;

   logic        clk = 1'b0;
   logic        resetn;
   logic        mem_valid, mem_stall, excp_req, excp_bd, eret, cp0_we;
   logic [4:0]  excp_code, cp0_waddr, cp0_raddr;
   logic [31:0] excp_pc, excp_badvaddr, cp0_wdata, cp0_rdata;
   logic [5:0]  ext_int;
   logic [32:0] bus;

   localparam logic [32:0] NOFL = 33'd0;
   localparam logic [32:0] EXFL = {1'b1, 32'hBFC0_0380};

   typedef struct {
      int          cyc;
      bit          is_bus;
      logic [32:0] exp;
      string       name;
   } exp_t;

   exp_t sb[$];
   exp_t item;
   int   cyc    = 0;
   int   n_cmp  = 0;
   int   n_fail = 0;
   logic [32:0] got;

   cp0_excp_unit dut (
      .clk             (clk),
      .resetn          (resetn),
      .mem_valid       (mem_valid),
      .mem_stall       (mem_stall),
      .excp_req        (excp_req),
      .excp_code       (excp_code),
      .excp_pc         (excp_pc),
      .excp_bd         (excp_bd),
      .excp_badvaddr   (excp_badvaddr),
      .eret            (eret),
      .ext_int         (ext_int),
      .cp0_we          (cp0_we),
      .cp0_waddr       (cp0_waddr),
      .cp0_wdata       (cp0_wdata),
      .cp0_raddr       (cp0_raddr),
      .cp0_rdata       (cp0_rdata),
      .CP0_to_ctrl_bus (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation queued for the current cycle
   always @(negedge clk) begin
      while (sb.size() != 0 && sb[0].cyc <= cyc) begin
         item = sb.pop_front();
         n_cmp++;
         got = item.is_bus ? bus : {1'b0, cp0_rdata};
         if (item.cyc != cyc || got !== item.exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", item.name, got, item.exp, item.cyc);
         end
      end
   end

   task automatic push(input bit is_bus, input logic [32:0] v, input string n);
      exp_t e;
      e.cyc = cyc; e.is_bus = is_bus; e.exp = v; e.name = n;
      sb.push_back(e);
   endtask

   // Immediate check of the combinational read port
   task automatic chk(input logic [31:0] v, input string n);
      #1;
      n_cmp++;
      if (cp0_rdata !== v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", n, cp0_rdata, v, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      mem_valid = 0; mem_stall = 0; excp_req = 0; excp_code = 0; excp_pc = 0;
      excp_bd = 0; excp_badvaddr = 0; eret = 0; cp0_we = 0; cp0_waddr = 0;
      cp0_wdata = 0; cp0_raddr = 0;
   endtask

   task automatic rd(input logic [4:0] a, input logic [31:0] v, input string n);
      clr();
      cp0_raddr = a;
      push(1'b0, {1'b0, v}, n);
      push(1'b1, NOFL, {n, "_bus"});
      step();
   endtask

   task automatic idle(input string n);
      clr();
      push(1'b1, NOFL, n);
      step();
   endtask

   task automatic mtc0(input logic [4:0] a, input logic [31:0] d, input string n);
      clr();
      mem_valid = 1; cp0_we = 1; cp0_waddr = a; cp0_wdata = d;
      push(1'b1, NOFL, n);
      step();
   endtask

   task automatic exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                      input logic [31:0] bva, input string n);
      clr();
      mem_valid = 1; excp_req = 1; excp_code = code; excp_pc = pc;
      excp_bd = bd; excp_badvaddr = bva;
      push(1'b1, EXFL, n);
      step();
   endtask

   initial begin
      resetn = 1'b0;
      ext_int = '0;
      clr();
      repeat (3) @(posedge clk);
      #1;
      mem_valid = 1; excp_req = 1; cp0_raddr = 5'd12;
      push(1'b1, NOFL, "reset_bus");
      chk(32'h0040_0000, "reset_status_now");
      step();
      resetn = 1'b1;

      rd(5'd9,  32'h0,         "rst_count");
      rd(5'd12, 32'h0040_0000, "rst_status");
      rd(5'd11, 32'h0,         "rst_compare");
      rd(5'd13, 32'h0,         "rst_cause");
      rd(5'd14, 32'h0,         "rst_epc");
      rd(5'd8,  32'h0,         "rst_badvaddr");
      rd(5'd3,  32'h0,         "unmapped");

      exc(5'h04, 32'hBFC0_1000, 1'b1, 32'h1234_5671, "adel_flush");
      rd(5'd14, 32'hBFC0_0FFC, "adel_epc");
      rd(5'd13, 32'h8000_0010, "adel_cause");
      rd(5'd8,  32'h1234_5671, "adel_badvaddr");
      rd(5'd12, 32'h0040_0002, "adel_status");

      exc(5'h0A, 32'h8000_0000, 1'b0, 32'h0, "nested_flush");
      rd(5'd14, 32'hBFC0_0FFC, "nested_epc");
      rd(5'd13, 32'h8000_0028, "nested_cause");
      rd(5'd8,  32'h1234_5671, "nested_badvaddr");

      clr(); mem_valid = 1; eret = 1;
      push(1'b1, {1'b1, 32'hBFC0_0FFC}, "eret1_bus");
      step();
      rd(5'd12, 32'h0040_0000, "eret1_status");

      // Timer: Count reaches Compare after eight cycles
      mtc0(5'd11, 32'd4,         "wr_compare");
      mtc0(5'd12, 32'h0000_8001, "wr_status");
      mtc0(5'd9,  32'd0,         "wr_count");
      for (int i = 0; i < 7; i++) idle("timer_wait");
      rd(5'd13, 32'h8000_0028, "pre_ti_cause");
      clr(); mem_valid = 1; excp_pc = 32'h0000_2000; cp0_raddr = 5'd13;
      push(1'b0, {1'b0, 32'hC000_8028}, "ti_cause");
      push(1'b1, EXFL, "int_flush");
      chk(32'hC000_8028, "timer_expired_now");
      step();
      rd(5'd13, 32'h4000_8000, "int_cause");
      rd(5'd14, 32'h0000_2000, "int_epc");
      rd(5'd12, 32'h0040_8003, "int_status");
      mtc0(5'd11, 32'd0, "clr_ti");
      rd(5'd13, 32'h0000_0000, "clr_ti_cause");

      // Exception drops a simultaneous MTC0
      clr(); mem_valid = 1; excp_req = 1; excp_code = 5'h0C; excp_pc = 32'h0000_3000;
      cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0;
      push(1'b1, EXFL, "drop_wr_flush");
      step();
      rd(5'd12, 32'h0040_8003, "drop_wr_status");
      rd(5'd13, 32'h0000_0030, "drop_wr_cause");
      rd(5'd14, 32'h0000_2000, "drop_wr_epc");

      clr(); mem_valid = 1; cp0_we = 1; cp0_waddr = 5'd14; cp0_wdata = 32'hA5A5_0004;
      cp0_raddr = 5'd14;
      push(1'b0, {1'b0, 32'hA5A5_0004}, "bypass_rdata");
      push(1'b1, NOFL, "bypass_bus");
      step();
      rd(5'd14, 32'hA5A5_0004, "bypass_epc");

      clr(); mem_valid = 1; eret = 1;
      push(1'b1, {1'b1, 32'hA5A5_0004}, "eret2_bus");
      step();
      rd(5'd12, 32'h0040_8001, "eret2_status");

      clr(); mem_valid = 1; mem_stall = 1; excp_req = 1; excp_code = 5'h04;
      excp_pc = 32'h0000_4000; excp_badvaddr = 32'hDEAD_BEE0;
      push(1'b1, NOFL, "stall_bus");
      step();
      rd(5'd12, 32'h0040_8001, "stall_status");
      rd(5'd14, 32'hA5A5_0004, "stall_epc");
      rd(5'd8,  32'h1234_5671, "stall_badvaddr");
      rd(5'd13, 32'h0000_0030, "stall_cause");

      // External interrupts: IP2 masked, IP7 enabled
      ext_int = 6'b000001;
      idle("ip2_sample");
      clr(); mem_valid = 1; cp0_raddr = 5'd13;
      push(1'b0, {1'b0, 32'h0000_0430}, "ip2_cause");
      push(1'b1, NOFL, "ip2_masked_bus");
      step();
      ext_int = 6'b100000;
      idle("ip7_sample");
      clr(); mem_valid = 1; excp_pc = 32'h0000_5000; cp0_raddr = 5'd13;
      push(1'b0, {1'b0, 32'h0000_8030}, "ip7_cause");
      push(1'b1, EXFL, "ip7_flush");
      step();
      ext_int = '0;
      rd(5'd14, 32'h0000_5000, "ip7_epc");

      // Reset asserted in the middle of an exception cycle
      clr(); mem_valid = 1; excp_req = 1; excp_code = 5'h05; cp0_raddr = 5'd12;
      cp0_we = 1; cp0_waddr = 5'd12; cp0_wdata = 32'h0;
      resetn = 1'b0;
      push(1'b1, NOFL, "midrst_bus");
      push(1'b0, {1'b0, 32'h0040_0000}, "midrst_status");
      step();
      resetn = 1'b1;
      rd(5'd14, 32'h0,         "post_rst_epc");
      rd(5'd13, 32'h0,         "post_rst_cause");
      rd(5'd8,  32'h0,         "post_rst_badvaddr");
      rd(5'd12, 32'h0040_0000, "post_rst_status");

      step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/cp0_excp_unit.md
# cp0_excp_unit

CP0 register file and exception/interrupt sequencer for the 5-stage MIPS core. It accepts exception, ERET and MTC0 requests from the MEM stage and samples external interrupts. It maintains BadVAddr, Count, Compare, Status, Cause and EPC, and drives `CP0_to_ctrl_bus`, the flush-and-redirect request consumed by the pipeline controller.

## Interface
- `EXC_VECTOR`, default 32'hBFC0_0380: general exception entry PC.
- `clk`  in  1  system clock, rising edge.
- `resetn`  in  1  reset, asynchronous, active-low.
- `mem_valid`  in  1  a valid instruction occupies MEM this cycle.
- `mem_stall`  in  1  MEM stage stalled; MEM-originated state updates are suppressed.
- `excp_req`  in  1  MEM instruction raised a synchronous exception.
- `excp_code`  in  5  ExcCode of that exception.
- `excp_pc`  in  32  PC of the MEM instruction.
- `excp_bd`  in  1  MEM instruction sits in a branch delay slot.
- `excp_badvaddr`  in  32  faulting address for AdEL (0x04) / AdES (0x05).
- `eret`  in  1  MEM instruction is ERET.
- `ext_int`  in  6  hardware interrupt lines, level-sensitive.
- `cp0_we`  in  1  MTC0 write enable.
- `cp0_waddr`  in  5  MTC0 register number (sel 0 only).
- `cp0_wdata`  in  32  MTC0 data.
- `cp0_raddr`  in  5  MFC0 register number.
- `cp0_rdata`  out  32  MFC0 data, combinational.
- `CP0_to_ctrl_bus`  out  33  [32] flush, [31:0] new_pc.

## Operation
- Registers and reset values:
  - BadVAddr(8) = 0
  - Count(9) = 0
  - Compare(11) = 0
  - Status(12) = 32'h0040_0000 (BEV=1)
  - Cause(13) = 0
  - EPC(14) = 0
  - Count tick phase = 0
- Writable bits:
  - Status: IM[15:8], EXL[1], IE[0].
  - Cause: IP[9:8] only.
  - Count, Compare, EPC: full 32 bits.
  - BadVAddr and writes to other addresses: ignored.
  - Unmapped read addresses return 0.
- Cause.IP[15:10] is registered every cycle from `ext_int`. IP[15] = `ext_int[5]` | Cause.TI(bit 30).
- `int_pend` = Status.IE & ~Status.EXL & |(Cause.IP[15:8] & Status.IM).
- Event priority, evaluated only when `mem_valid` & ~`mem_stall`:
  1. Interrupt (`int_pend`): ExcCode = 0x00.
  2. `excp_req`: ExcCode = `excp_code`.
  3. `eret`.
  4. `cp0_we`.
- Exception taken (interrupt or `excp_req`):
  - flush = 1, new_pc = `EXC_VECTOR`.
  - At the edge, Cause.ExcCode[6:2] is loaded.
  - If Status.EXL was 0: EPC = `excp_bd` ? `excp_pc` − 4 : `excp_pc`, and Cause.BD[31] = `excp_bd`. If EXL was already 1, EPC and BD are unchanged.
  - Status.EXL is set to 1.
  - BadVAddr is loaded with `excp_badvaddr` only for codes 0x04/0x05.
  - A simultaneous `cp0_we` is dropped.
- ERET:
  - flush = 1, new_pc = EPC (the current register value).
  - Status.EXL is cleared at the edge.
  - A simultaneous `cp0_we` is dropped.
- Otherwise flush = 0 and new_pc = 0.
- Count/timer:
  - The tick phase toggles every cycle. Count increments (mod 2^32) on cycles where the phase is 1.
  - TI is set at the edge when the next Count value equals Compare and Compare ≠ 0.
  - An MTC0 to Count loads Count, clears the phase, and overrides that cycle's increment.
  - An MTC0 to Compare loads Compare and clears TI. Clearing wins over a same-cycle set.
- Read bypass: when `cp0_we` & (`cp0_raddr` == `cp0_waddr`) and no exception or ERET is taken, `cp0_rdata` returns the masked write value. Otherwise it returns the register value.

## Timing
- `CP0_to_ctrl_bus` is combinational from the current inputs and registers. Flush is high in the same cycle the event is in MEM, for exactly the cycles the event condition holds.
- All register updates occur at the rising edge ending the event cycle. Updated values are visible in the following cycle.
- While `mem_stall` = 1: flush = 0 and no MEM-originated update occurs. Count, TI and IP sampling continue.
- `resetn` low at any time: all registers take reset values immediately. While low, flush = 0, new_pc = 0, and `cp0_rdata` reflects the reset values.

## Test plan
- Reset, then read Status -> 32'h0040_0000. Read every other register -> 0. Flush stays 0.
- `excp_req`, code 0x04, pc 0xBFC0_1000, bd=1, badvaddr 0x1234_5671 ->
  - same cycle: bus = {1, 32'hBFC0_0380}
  - next cycle: EPC = 0xBFC0_0FFC, Cause.BD = 1, Cause.ExcCode = 0x04, BadVAddr = 0x1234_5671, Status.EXL = 1.
- With EXL=1, a second exception at pc 0x8000_0000 -> EPC unchanged, flush = 1. Then ERET -> bus = {1, old EPC} and EXL cleared next cycle.
- MTC0 Compare = 4, Status = 0x0000_8001, Count = 0 -> TI sets on the edge that makes Count = 4 (8 cycles later). With a valid MEM instruction, the interrupt is taken and Cause.ExcCode = 0. MTC0 Compare then clears TI.
- Same-cycle `excp_req` and `cp0_we` to Status with data 0 -> write dropped, EXL = 1. Same-cycle MTC0 EPC with read of EPC -> `cp0_rdata` returns the write data.
- `mem_stall` = 1 with `excp_req` -> no flush and no register change. `resetn` pulsed low mid-event -> all registers reset immediately and the bus reads {0, 0}.
